// File: rtl/bcd_scan_display.sv
// Multiplexed seven-segment driver for a bank of BCD digits.
// Has a snapshot register, a scan divider, leading-zero blanking and invalid-code detection.
module bcd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DIV_W      = 16
) (
  input  logic                    p_clk_in,
  input  logic                    p_rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    bad_code
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [3:0]            snap [NUM_DIGITS];
  logic [DIV_W-1:0]      div;
  logic [IDX_W-1:0]      idx;

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  any_bad;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero; built from the top down.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    zero_from = '0;
    any_bad   = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      all_zero = all_zero & (snap[NUM_DIGITS-1-k] == 4'd0);
      zero_from[NUM_DIGITS-1-k] = all_zero;
      any_bad = any_bad | (snap[k] > 4'd9);
    end
  end

  always_comb begin
    an_next = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = (idx != IDX_W'(i));
    end
    if (blank_lz && (idx != '0) && zero_from[idx]) begin
      seg_next = '1;
    end else begin
      seg_next = decode(snap[idx]);
    end
  end

  always_ff @(posedge p_clk_in) begin
    if (!p_rst) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        snap[i] <= '0;
      end
      div      <= '0;
      idx      <= '0;
      seg      <= '1;
      an       <= '1;
      bad_code <= 1'b0;
    end else begin
      if (load) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          snap[i] <= digits[4*i +: 4];
        end
      end
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        div <= div + 1'b1;
      end
      seg      <= seg_next;
      an       <= an_next;
      bad_code <= any_bad;
    end
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the decimal counter stage.
- Captures a bank of NUM_DIGITS 4-bit BCD digits, decodes each to a seven-segment pattern, and time-multiplexes them onto one shared segment bus with one-hot digit enables.
- Optional leading-zero blanking; invalid codes are flagged.
- Sits between the counter chain and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4: number of BCD digits scanned (2..8).
- SCAN_DIV, 50000: clock cycles each digit stays enabled (≥2).
- DIV_W, 16: width of the scan divider counter; must satisfy 2**DIV_W ≥ SCAN_DIV.

Ports:
- p_clk_in  input  1  system clock, all logic on rising edge.
- p_rst  input  1  synchronous reset, active-low.
- digits  input  4*NUM_DIGITS  BCD digits; digits[3:0] is least significant (digit 0).
- load  input  1  capture strobe; snapshot updates on any edge where load=1.
- blank_lz  input  1  leading-zero blanking enable.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
- an  output  NUM_DIGITS  digit enables, one-hot active-low, registered.
- bad_code  output  1  high while any snapshot digit is >9, registered.

Behaviour:
- Reset (p_rst=0 at an edge):
  - snapshot=0, divider=0, idx=0.
  - seg=7'b1111111, an=all 1s, bad_code=0.
  - Reset wins over load and scan advance.
- Snapshot: on an edge with load=1, snapshot<=digits. It holds otherwise.
- Divider: counts 0..SCAN_DIV-1 every cycle, then wraps to 0.
  - On the wrap edge, idx advances by 1.
  - idx wraps from NUM_DIGITS-1 to 0.
- Output register: each cycle, an<=~(1<<idx) and seg<=decode(snapshot[idx]), using the current (pre-edge) idx/snapshot values. Latency:
  - Load to visible segment change: 2 edges (load edge, then output edge).
  - idx advance to an change: 1 edge.
  - First cycle after reset release: an[0]=0, showing digit 0.
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10..15 -> dash 0111111.
- Leading-zero blanking, when blank_lz=1:
  - Digit i>0 is blanked (seg=1111111) if snapshot digits i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - an still asserts for blanked digits.
  - An invalid code counts as non-zero.
- bad_code: registered OR of (snapshot digit>9) over all digits, one edge after the snapshot update.
- blank_lz changes take effect on the next output edge; there is no scan restart.
- load held high continuously: snapshot tracks digits every cycle.
- Reset mid-scan: next edge after release behaves as post-reset first cycle (idx=0, divider=0).

Test Plan (SCAN_DIV=4, NUM_DIGITS=4):
1. Hold p_rst=0 for 3 edges, then release. During reset: seg=1111111, an=1111, bad_code=0. First edge after release: an=1110, seg=1000000.
2. digits=16'h1234, load pulse 1 cycle. Two edges later seg=0011001 (digit 0 = 4). an sequence is 1110, 1101, 1011, 0111, each held 4 cycles, with seg 4, 3, 2, 1 respectively; it then wraps to 1110.
3. digits=16'h0007, blank_lz=1:
   - an 1110: seg=1111000.
   - an 1101, 1011, 0111: seg=1111111.
   - With blank_lz=0, the same slots show 1000000.
4. digits=16'h00A0, blank_lz=1, load:
   - bad_code=1 one edge after the snapshot.
   - Digit 1 shows 0111111; digit 0 shows 1000000.
   - Digits 2 and 3 are blanked.
   - Reloading 16'h0000 clears bad_code.
5. load=0 while digits changes to 16'h9999: display keeps the old snapshot. Then load=1 for one cycle: all slots show 0010000.
6. Assert p_rst=0 for one edge while idx=2 mid-count. After release: an=1110, idx restarts at 0, snapshot=0, and all slots show 1000000 (blank_lz=0).
